// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 host transmitter types and constants
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SHIFT,
    ACK,
    WAIT_IDLE,
    ERR
  } ps2_state_e;

  localparam logic [1:0] PS2_ERR_NONE    = 2'd0;
  localparam logic [1:0] PS2_ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] PS2_ERR_NOACK   = 2'd2;

  localparam logic [3:0] PS2_EDGE_PAR  = 4'd9;
  localparam logic [3:0] PS2_EDGE_STOP = 4'd10;
  localparam logic [3:0] PS2_EDGE_ACK  = 4'd11;

  localparam int PS2_START_CYC = 16;

  // Parity bit that makes the total count of ones in data+parity odd.
  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizers for PS2_CLK/PS2_DATA plus clock falling-edge detect
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic clk_fall_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;

  // Idle lines are pulled high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_s_o    = clk_sync_q[1];
  assign data_s_o   = data_sync_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Define PS2_TX_ACK_CHECK_EN to flag a missing device ACK at clock edge 11.
module ps2_host_tx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int INHIBIT_US = 120,
  parameter int TIMEOUT_MS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);
  import ps2_pkg::*;

  localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int PH_MAX      = (INHIBIT_CYC > PS2_START_CYC) ? INHIBIT_CYC : PS2_START_CYC;
  localparam int PH_W        = $clog2(PH_MAX);
  localparam int TO_W        = $clog2(TIMEOUT_CYC);

  localparam logic [PH_W-1:0] INH_LAST   = PH_W'(INHIBIT_CYC - 1);
  localparam logic [PH_W-1:0] START_LAST = PH_W'(PS2_START_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

  ps2_state_e      state_q;
  logic [7:0]      data_q;
  logic            par_q;
  logic [3:0]      edge_q;
  logic [PH_W-1:0] ph_q;
  logic [TO_W-1:0] to_q;
  logic            tx_ready_q, clk_oe_q, data_oe_q, busy_q, done_q, err_q;
  logic [1:0]      err_code_q;

  logic       clk_s, data_s, fall;
  logic [3:0] edge_nx;
  logic       counting, timeout;

  ps2_line_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .clk_s_o    (clk_s),
    .data_s_o   (data_s),
    .clk_fall_o (fall)
  );

  assign edge_nx  = edge_q + 4'd1;
  assign counting = (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE);
  assign timeout  = counting && (to_q == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      data_q     <= 8'h00;
      par_q      <= 1'b0;
      edge_q     <= 4'd0;
      ph_q       <= '0;
      to_q       <= '0;
      tx_ready_q <= 1'b1;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= PS2_ERR_NONE;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // A stalled device wins over any edge arriving in the same cycle.
      if (timeout) begin
        state_q    <= ERR;
        clk_oe_q   <= 1'b0;
        data_oe_q  <= 1'b0;
        err_code_q <= PS2_ERR_TIMEOUT;
      end else begin
        if (counting) to_q <= to_q + 1'b1;
        case (state_q)
          IDLE: if (tx_valid) begin
            data_q     <= tx_data;
            par_q      <= ps2_odd_parity(tx_data);
            err_code_q <= PS2_ERR_NONE;
            edge_q     <= 4'd0;
            ph_q       <= '0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            clk_oe_q   <= 1'b1;
            state_q    <= INHIBIT;
          end
          INHIBIT: if (ph_q == INH_LAST) begin
            ph_q      <= '0;
            data_oe_q <= 1'b1;
            state_q   <= START;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
          START: if (ph_q == START_LAST) begin
            ph_q     <= '0;
            to_q     <= '0;
            clk_oe_q <= 1'b0;
            state_q  <= SHIFT;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
          SHIFT: if (fall) begin
            edge_q <= edge_nx;
            if (edge_nx == PS2_EDGE_STOP) begin
              data_oe_q <= 1'b0;
              state_q   <= ACK;
            end else if (edge_nx == PS2_EDGE_PAR) begin
              data_oe_q <= ~par_q;
            end else begin
              data_oe_q <= ~data_q[edge_q[2:0]];
            end
          end
          ACK: if (fall) begin
            edge_q <= edge_nx;
`ifdef PS2_TX_ACK_CHECK_EN
            if (data_s) begin
              err_code_q <= PS2_ERR_NOACK;
              state_q    <= ERR;
            end else begin
              state_q <= WAIT_IDLE;
            end
`else
            state_q <= WAIT_IDLE;
`endif
          end
          WAIT_IDLE: if (clk_s && data_s) begin
            done_q     <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
          ERR: begin
            err_q      <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            state_q    <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tx_ready    = tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with an open-drain device model
module tb_ps2_host_tx;

  localparam int CLK_HZ      = 2_000_000;
  localparam int INHIBIT_US  = 60;
  localparam int TIMEOUT_MS  = 1;
  localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int H           = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_i, ps2_data_i;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, err;
  logic [1:0] err_code;
  logic       dev_clk_low, dev_data_low;

  int total = 0;
  int bad   = 0;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ     (CLK_HZ),
    .INHIBIT_US (INHIBIT_US),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_n = 0, err_n = 0, both_n = 0, acc_n = 0;
  int done_cyc = 0, err_cyc = 0, rdy_fall_cyc = 0;
  int clk_rise_cyc = 0, clk_fall_cyc = 0, data_rise_cyc = 0, data_fall_cyc = 0;
  logic       done_ready = 1'b0, err_ready = 1'b0;
  logic [1:0] done_code = 2'd0, err_code_at = 2'd0;
  logic       prev_ready = 1'b1, prev_clk_oe = 1'b0, prev_data_oe = 1'b0;

  always @(negedge clk) begin
    if (done) begin
      done_n     <= done_n + 1;
      done_cyc   <= cyc;
      done_ready <= tx_ready;
      done_code  <= err_code;
    end
    if (err) begin
      err_n       <= err_n + 1;
      err_cyc     <= cyc;
      err_ready   <= tx_ready;
      err_code_at <= err_code;
    end
    if (done && err) both_n <= both_n + 1;
    if (prev_ready && !tx_ready) begin
      acc_n        <= acc_n + 1;
      rdy_fall_cyc <= cyc;
    end
    if (!prev_clk_oe && ps2_clk_oe) clk_rise_cyc <= cyc;
    if (prev_clk_oe && !ps2_clk_oe) clk_fall_cyc <= cyc;
    if (!prev_data_oe && ps2_data_oe && ps2_clk_oe) data_rise_cyc <= cyc;
    if (prev_data_oe && !ps2_data_oe) data_fall_cyc <= cyc;
    prev_ready   <= tx_ready;
    prev_clk_oe  <= ps2_clk_oe;
    prev_data_oe <= ps2_data_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected wire order: 8 data bits LSB first, odd parity, stop bit.
  function automatic logic [10:0] frame_model(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  // Device: waits for request-to-send, then clocks n_falls pulses and reads data on rising edges.
  task automatic dev_frame(input int n_falls, input bit ack, output logic [10:0] seen, output bit ok);
    int w;
    seen = '0;
    w = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    ok = (w < 5000);
    if (ok) begin
      repeat (5) @(negedge clk);
      for (int i = 1; i <= n_falls; i++) begin
        if (i == 11) dev_data_low = ack;
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        if (i <= 10) seen[i-1] = ps2_data_i;
        if (i == 11) dev_data_low = 1'b0;
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, input bit poke, input string tag);
    logic [10:0] seen, exp;
    bit ok, exp_noack;
    int d0, e0, w;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    d0 = done_n;
    e0 = err_n;
    if (poke) begin
      repeat (30) @(negedge clk);
      tx_data  = b ^ 8'h55;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
    dev_frame(11, ack, seen, ok);
    check({tag, "_dev_started"}, 32'(ok), 32'd1);
    w = 0;
    while (done_n == d0 && err_n == e0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    exp = frame_model(b);
    check({tag, "_bits"}, 32'(seen), 32'(exp));
    check({tag, "_clk_hold"}, clk_fall_cyc - clk_rise_cyc, INHIBIT_CYC + 16);
    check({tag, "_start_ofs"}, data_rise_cyc - clk_rise_cyc, INHIBIT_CYC);
    check({tag, "_oe_vs_ready"}, clk_rise_cyc - rdy_fall_cyc, 0);
`ifdef PS2_TX_ACK_CHECK_EN
    exp_noack = !ack;
`else
    exp_noack = 1'b0;
`endif
    if (exp_noack) begin
      check({tag, "_err_cnt"}, err_n - e0, 1);
      check({tag, "_done_cnt"}, done_n - d0, 0);
      check({tag, "_err_code"}, 32'(err_code_at), 32'd2);
      check({tag, "_ready_on_err"}, 32'(err_ready), 32'd1);
    end else begin
      check({tag, "_done_cnt"}, done_n - d0, 1);
      check({tag, "_err_cnt"}, err_n - e0, 0);
      check({tag, "_code"}, 32'(done_code), 32'd0);
      check({tag, "_ready_on_done"}, 32'(done_ready), 32'd1);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [10:0] seen, exp;
    bit ok;
    int d0, e0, a0, w;
    rst          = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err, err_code}), 32'h80);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    run_frame(8'hED, 1'b1, 1'b0, "ed");
    run_frame(8'hF4, 1'b1, 1'b0, "f4");

    // Device never clocks: whole-frame timeout.
    @(negedge clk);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    d0 = done_n;
    e0 = err_n;
    w  = 0;
    while (err_n == e0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("to_err_cnt", err_n - e0, 1);
    check("to_code", 32'(err_code_at), 32'd1);
    check("to_release_cyc", data_fall_cyc - clk_fall_cyc, TIMEOUT_CYC);
    check("to_err_cyc", err_cyc - clk_fall_cyc, TIMEOUT_CYC + 1);
    check("to_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("to_no_done", done_n - d0, 0);

    run_frame(8'h96, 1'b0, 1'b0, "noack");

    // Reset mid-frame after five bits.
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(5, 1'b1, seen, ok);
    check("mr_dev_started", 32'(ok), 32'd1);
    exp = frame_model(8'hA5);
    check("mr_bits", 32'(seen[4:0]), 32'(exp[4:0]));
    rst = 1'b0;
    #1;
    check("mr_release", 32'({tx_ready, ps2_clk_oe, ps2_data_oe, busy}), 32'h8);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    run_frame(8'hFF, 1'b1, 1'b0, "ff");

    // tx_valid held across done: second byte accepted on the done cycle.
    @(negedge clk);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'hC3;
    repeat (2) @(negedge clk);
    a0 = acc_n;
    d0 = done_n;
    dev_frame(11, 1'b1, seen, ok);
    exp = frame_model(8'h5A);
    check("b2b_bits1", 32'(seen), 32'(exp));
    w = 0;
    while (done_n == d0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    tx_valid = 1'b0;
    check("b2b_done1", done_n - d0, 1);
    check("b2b_ready_on_done", 32'(done_ready), 32'd1);
    check("b2b_accept_cnt", acc_n - a0, 1);
    check("b2b_accept_cyc", rdy_fall_cyc - done_cyc, 1);
    d0 = done_n;
    dev_frame(11, 1'b1, seen, ok);
    exp = frame_model(8'hC3);
    check("b2b_bits2", 32'(seen), 32'(exp));
    w = 0;
    while (done_n == d0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("b2b_done2", done_n - d0, 1);

    run_frame(8'h3C, 1'b1, 1'b1, "poke");

    for (int i = 0; i < 3; i++) run_frame(8'($urandom), 1'b1, 1'b0, "rnd");

    check("done_err_exclusive", both_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
